// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared types and constants for the ALU issue/writeback stage
// Contents: ALUOp encodings, 16-bit instruction field positions, FSM state enum,
// decoded-instruction struct and its decode helper.
package alu_issue_pkg;

  localparam logic [2:0] OP_MOV     = 3'b000;
  localparam logic [2:0] OP_NOT     = 3'b001;
  localparam logic [2:0] OP_ADD     = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_OR      = 3'b100;
  localparam logic [2:0] OP_AND     = 3'b101;
  localparam logic [2:0] OP_SLT     = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  // Instruction layout: [15:13] op, [12:10] rd, [9:7] rs, [6:4] rt, [3] cin, [2:0] reserved
  localparam int OP_LSB  = 13;
  localparam int RD_LSB  = 10;
  localparam int RS_LSB  = 7;
  localparam int RT_LSB  = 4;
  localparam int CIN_BIT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       cin;
  } instr_t;

  // Takes only the meaningful bits [15:3]; the reserved low bits never reach decode.
  function automatic instr_t decode_instr(input logic [15:3] bits);
    instr_t d;
    d.op  = bits[OP_LSB+2 -: 3];
    d.rd  = bits[RD_LSB+2 -: 3];
    d.rs  = bits[RS_LSB+2 -: 3];
    d.rt  = bits[RT_LSB+2 -: 3];
    d.cin = bits[CIN_BIT];
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// rtl/alu_issue_stage_regfile.sv - NREGS x WIDTH register file, r0 hardwired to zero
// Ports: clk, rst_n (sync active-low clear of every entry),
//        rd_addr_a/rd_data_a, rd_addr_b/rd_data_b (combinational reads),
//        wr_en/wr_addr/wr_data (synchronous write; writes to r0 are discarded).
module alu_regfile #(
  parameter int WIDTH = 32,
  parameter int NREGS = 8,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
    regs_d[0] = '0;  // r0 never holds anything but zero
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_data_a = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - issue/writeback stage in front of the combinational 7-op ALU
// Ports: clk, rst_n (sync active-low); instr_valid/instr_ready/instr (16-bit instruction);
//        alu_r2/alu_r3/alu_op/alu_cin to the ALU, alu_r1 back from it;
//        wb_valid/wb_addr/wb_data writeback pulse; illegal_op pulse for dropped op 3'b111.
// Optional: define ALU_ISSUE_ZERO_FLAG_EN to add zero_flag (result==0, updated in WB).
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [15:0]      instr,
  output logic [WIDTH-1:0] alu_r2,
  output logic [WIDTH-1:0] alu_r3,
  output logic [2:0]       alu_op,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_r1,
  output logic             wb_valid,
  output logic [2:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  output logic             zero_flag,
`endif
  output logic             illegal_op
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_r2_q, alu_r2_d;
  logic [WIDTH-1:0] alu_r3_q, alu_r3_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             alu_cin_q, alu_cin_d;
  logic [2:0]       rd_q, rd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             wb_valid_q, wb_valid_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] rs_data, rt_data;
  instr_t           dec;
  logic [2:0]       unused_instr_bits;

  assign dec               = decode_instr(instr[15:3]);
  assign unused_instr_bits = instr[2:0];

  alu_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (dec.rs),
    .rd_data_a (rs_data),
    .rd_addr_b (dec.rt),
    .rd_data_b (rt_data),
    .wr_en     (state_q == WB),
    .wr_addr   (rd_q),
    .wr_data   (result_q)
  );

  always_comb begin
    state_d    = state_q;
    alu_r2_d   = alu_r2_q;
    alu_r3_d   = alu_r3_q;
    alu_op_d   = alu_op_q;
    alu_cin_d  = alu_cin_q;
    rd_d       = rd_q;
    result_d   = result_q;
    wb_valid_d = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          if (dec.op == OP_ILLEGAL) begin
            // Dropped outright: the ALU-facing registers keep their old contents.
            illegal_d = 1'b1;
          end else begin
            alu_r2_d  = rs_data;
            alu_r3_d  = rt_data;
            alu_op_d  = dec.op;
            alu_cin_d = dec.cin;
            rd_d      = dec.rd;
            state_d   = EXEC;
          end
        end
      end
      EXEC: begin
        result_d   = alu_r1;
        wb_valid_d = 1'b1;  // registered so it is high for exactly the WB cycle
        state_d    = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      alu_r2_q   <= '0;
      alu_r3_q   <= '0;
      alu_op_q   <= OP_MOV;
      alu_cin_q  <= 1'b0;
      rd_q       <= '0;
      result_q   <= '0;
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_r2_q   <= alu_r2_d;
      alu_r3_q   <= alu_r3_d;
      alu_op_q   <= alu_op_d;
      alu_cin_q  <= alu_cin_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      wb_valid_q <= wb_valid_d;
      illegal_q  <= illegal_d;
    end
  end

`ifdef ALU_ISSUE_ZERO_FLAG_EN
  logic zero_flag_q, zero_flag_d;

  always_comb begin
    zero_flag_d = zero_flag_q;
    if (state_q == WB) begin
      zero_flag_d = (result_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_flag_q <= 1'b0;
    end else begin
      zero_flag_q <= zero_flag_d;
    end
  end

  assign zero_flag = zero_flag_q;
`endif

  assign instr_ready = (state_q == IDLE);
  assign alu_r2      = alu_r2_q;
  assign alu_r3      = alu_r3_q;
  assign alu_op      = alu_op_q;
  assign alu_cin     = alu_cin_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = rd_q;
  assign wb_data     = result_q;
  assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage
module tb_alu_issue_stage;
  import alu_issue_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             instr_valid;
  logic             instr_ready;
  logic [15:0]      instr;
  logic [WIDTH-1:0] alu_r2, alu_r3, alu_r1;
  logic [2:0]       alu_op;
  logic             alu_cin;
  logic             wb_valid;
  logic [2:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             illegal_op;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  logic             zero_flag;
`endif

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] model [8];

  logic [WIDTH-1:0] obs_r2, obs_r3, obs_wbd, exp_r2, exp_r3, exp_res;
  logic [2:0]       obs_op, obs_wba;
  logic             obs_cin, obs_rdy, obs_wbv;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(WIDTH), .NREGS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_r2      (alu_r2),
    .alu_r3      (alu_r3),
    .alu_op      (alu_op),
    .alu_cin     (alu_cin),
    .alu_r1      (alu_r1),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    .zero_flag   (zero_flag),
`endif
    .illegal_op  (illegal_op)
  );

  function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b, input logic cin);
    case (op)
      3'd0:    return a;
      3'd1:    return ~a;
      3'd2:    return a + b + WIDTH'(cin);
      3'd3:    return a - b;
      3'd4:    return a | b;
      3'd5:    return a & b;
      3'd6:    return ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
      default: return '0;
    endcase
  endfunction

  // Stand-in for the combinational ALU downstream of the stage.
  always_comb alu_r1 = ref_alu(alu_op, alu_r2, alu_r3, alu_cin);

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt, input logic cin);
    return {op, rd, rs, rt, cin, 3'b000};
  endfunction

  // Issues one legal instruction, records what the stage showed in EXEC and WB,
  // and advances the register model. Returns at the WB-cycle negedge.
  task automatic run_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [2:0] rt, input logic cin);
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout instr_ready=%0b required=1", instr_ready);
    end
    exp_r2  = (rs == 3'd0) ? '0 : model[rs];
    exp_r3  = (rt == 3'd0) ? '0 : model[rt];
    exp_res = ref_alu(op, exp_r2, exp_r3, cin);
    instr_valid = 1'b1;
    instr = enc(op, rd, rs, rt, cin);
    @(negedge clk);
    instr_valid = 1'b0;
    obs_r2 = alu_r2; obs_r3 = alu_r3; obs_op = alu_op; obs_cin = alu_cin; obs_rdy = instr_ready;
    @(negedge clk);
    obs_wbv = wb_valid; obs_wba = wb_addr; obs_wbd = wb_data;
    if (rd != 3'd0) model[rd] = exp_res;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = '0;
    checks++;
    if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", instr_ready); end
    checks++;
    if ({alu_r2, alu_r3, wb_data} !== '0) begin
      errors++; $display("FAIL reset_data r2=%0h r3=%0h wbd=%0h exp=0", alu_r2, alu_r3, wb_data);
    end
    checks++;
    if ({alu_op, alu_cin, wb_valid, illegal_op, wb_addr} !== 9'd0) begin
      errors++;
      $display("FAIL reset_ctrl op=%0d cin=%0b wbv=%0b ill=%0b wba=%0d exp=0", alu_op, alu_cin, wb_valid, illegal_op, wb_addr);
    end
  endtask

  task automatic test_add;
    run_instr(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1);  // r1 = 1
    run_instr(OP_ADD, 3'd1, 3'd1, 3'd1, 1'b0);  // r1 = 2
    run_instr(OP_ADD, 3'd1, 3'd1, 3'd1, 1'b1);  // r1 = 5
    run_instr(OP_ADD, 3'd2, 3'd1, 3'd0, 1'b1);  // r2 = 6
    run_instr(OP_ADD, 3'd2, 3'd2, 3'd0, 1'b1);  // r2 = 7
    run_instr(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b1);
    checks++;
    if (obs_r2 !== 32'd5 || obs_r3 !== 32'd7) begin
      errors++; $display("FAIL add_operands r2=%0d r3=%0d exp=5,7", obs_r2, obs_r3);
    end
    checks++;
    if (obs_op !== 3'b010 || obs_cin !== 1'b1 || obs_rdy !== 1'b0) begin
      errors++; $display("FAIL add_ctrl op=%0d cin=%0b rdy=%0b exp=2,1,0", obs_op, obs_cin, obs_rdy);
    end
    checks++;
    if (obs_wbv !== 1'b1 || obs_wba !== 3'd3 || obs_wbd !== 32'd13) begin
      errors++; $display("FAIL add_wb v=%0b a=%0d d=%0d exp=1,3,13", obs_wbv, obs_wba, obs_wbd);
    end
  endtask

  task automatic test_back_to_back;
    run_instr(OP_SUB, 3'd4, 3'd3, 3'd1, 1'b0);
    checks++;
    if (obs_r2 !== 32'd13 || obs_r3 !== 32'd5) begin
      errors++; $display("FAIL b2b_operands r2=%0d r3=%0d exp=13,5", obs_r2, obs_r3);
    end
    checks++;
    if (obs_wbd !== 32'd8 || obs_wba !== 3'd4) begin
      errors++; $display("FAIL b2b_wb d=%0d a=%0d exp=8,4", obs_wbd, obs_wba);
    end
  endtask

  task automatic test_r0_write;
    run_instr(OP_MOV, 3'd0, 3'd3, 3'd0, 1'b0);
    checks++;
    if (obs_wbv !== 1'b1 || obs_wba !== 3'd0 || obs_wbd !== 32'd13) begin
      errors++; $display("FAIL r0_wb v=%0b a=%0d d=%0d exp=1,0,13", obs_wbv, obs_wba, obs_wbd);
    end
    run_instr(OP_MOV, 3'd6, 3'd0, 3'd0, 1'b0);
    checks++;
    if (obs_wbd !== 32'd0) begin errors++; $display("FAIL r0_read d=%0h exp=0", obs_wbd); end
  endtask

  task automatic test_slt;
    run_instr(OP_NOT, 3'd1, 3'd0, 3'd0, 1'b0);  // r1 = FFFFFFFF
    run_instr(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1);  // r2 = 1
    run_instr(OP_SLT, 3'd5, 3'd1, 3'd2, 1'b0);
    checks++;
    if (obs_wbd !== 32'd1) begin errors++; $display("FAIL slt_neg_lt d=%0h exp=1", obs_wbd); end
    run_instr(OP_SLT, 3'd5, 3'd2, 3'd1, 1'b0);
    checks++;
    if (obs_wbd !== 32'd0) begin errors++; $display("FAIL slt_swap d=%0h exp=0", obs_wbd); end
  endtask

  task automatic test_illegal;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = enc(OP_ILLEGAL, 3'd1, 3'd3, 3'd3, 1'b1);
    @(negedge clk);
    instr_valid = 1'b0;
    checks++;
    if (illegal_op !== 1'b1 || wb_valid !== 1'b0 || instr_ready !== 1'b1) begin
      errors++; $display("FAIL illegal_pulse ill=%0b wbv=%0b rdy=%0b exp=1,0,1", illegal_op, wb_valid, instr_ready);
    end
    @(negedge clk);
    checks++;
    if (illegal_op !== 1'b0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL illegal_end ill=%0b wbv=%0b exp=0,0", illegal_op, wb_valid);
    end
    for (int k = 1; k < 8; k++) begin
      run_instr(OP_MOV, 3'(k), 3'(k), 3'd0, 1'b0);
      checks++;
      if (obs_wbd !== exp_res) begin
        errors++; $display("FAIL illegal_regs r%0d got=%0h exp=%0h", k, obs_wbd, exp_res);
      end
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      logic [2:0] op, rd, rs, rt;
      logic cin;
      op  = 3'($urandom_range(0, 6));
      rd  = 3'($urandom_range(0, 7));
      rs  = 3'($urandom_range(0, 7));
      rt  = 3'($urandom_range(0, 7));
      cin = 1'($urandom_range(0, 1));
      run_instr(op, rd, rs, rt, cin);
      checks++;
      if (obs_r2 !== exp_r2 || obs_r3 !== exp_r3 || obs_op !== op) begin
        errors++;
        $display("FAIL rand_exec #%0d r2=%0h r3=%0h op=%0d exp=%0h,%0h,%0d", n, obs_r2, obs_r3, obs_op, exp_r2, exp_r3, op);
      end
      checks++;
      if (obs_wbv !== 1'b1 || obs_wba !== rd || obs_wbd !== exp_res) begin
        errors++;
        $display("FAIL rand_wb #%0d v=%0b a=%0d d=%0h exp=1,%0d,%0h", n, obs_wbv, obs_wba, obs_wbd, rd, exp_res);
      end
    end
  endtask

  task automatic test_reset_mid_exec;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = enc(OP_ADD, 3'd7, 3'd3, 3'd3, 1'b1);
    @(negedge clk);
    instr_valid = 1'b0;
    checks++;
    if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_exec_entry rdy=%0b exp=0", instr_ready); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = '0;
    checks++;
    if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_no_wb0 wbv=%0b exp=0", wb_valid); end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || instr_ready !== 1'b1) begin
      errors++; $display("FAIL rst_after wbv=%0b rdy=%0b exp=0,1", wb_valid, instr_ready);
    end
    for (int k = 1; k < 8; k++) begin
      run_instr(OP_MOV, 3'(k), 3'(k), 3'd0, 1'b0);
      checks++;
      if (obs_wbd !== 32'd0) begin errors++; $display("FAIL rst_regs r%0d got=%0h exp=0", k, obs_wbd); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_r0_write();
    test_slt();
    test_illegal();
    test_random();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
